// File: rtl/keypad_entry.sv
// Turns debounced keypad presses into digit entry and operator/enter/clear events.
// Latency: ready rising -> event pulses five cycles later; no backpressure, one action per physical press.
module keypad_entry #(
    parameter  int WIDTH          = 8,
    parameter  int MAX_DIGITS     = 3,
    parameter  int RELEASE_CYCLES = 50000,
    localparam int CW             = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       tecla_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] entry_o,
    output logic [CW-1:0]    digit_count_o,
    output logic             overflow_o,
    output logic [WIDTH-1:0] operand_o,
    output logic             operand_valid_o,
    output logic [1:0]       op_code_o,
    output logic             op_valid_o,
    output logic [3:0]       key_code_o,
    output logic             key_pulse_o,
    output logic             busy_o
);

    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam int XW = WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        EXEC     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            ready_meta_q;
    logic            rs_q;
    logic [RW-1:0]   rel_cnt_q, rel_cnt_d;
    logic [7:0]      key_reg_q, key_reg_d;

    logic [WIDTH-1:0] entry_q, entry_d;
    logic [CW-1:0]    digit_count_q, digit_count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             operand_valid_q, operand_valid_d;
    logic [1:0]       op_code_q, op_code_d;
    logic             op_valid_q, op_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_pulse_q, key_pulse_d;

    logic [XW-1:0]    entry_ext;
    logic [XW-1:0]    digit_ext;
    logic [XW-1:0]    acc;
    logic [3:0]       op_offset;
    logic             is_key;

    // ready is asynchronous to our sampling; two flops before any decision is made on it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_meta_q <= 1'b0;
            rs_q         <= 1'b0;
        end else begin
            ready_meta_q <= ready_i;
            rs_q         <= ready_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rel_cnt_q <= '0;
            key_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
            key_reg_q <= key_reg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        key_reg_d = key_reg_q;
        unique case (state_q)
            IDLE: begin
                if (rs_q) state_d = CAPTURE;
            end
            CAPTURE: begin
                rel_cnt_d = '0;
                if (rs_q) begin
                    key_reg_d = tecla_i;
                    state_d   = EXEC;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            EXEC: begin
                rel_cnt_d = '0;
                state_d   = WAIT_REL;
            end
            WAIT_REL: begin
                // any synced-high cycle restarts the release window, so bounce never re-arms
                if (rs_q) begin
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == RW'(RELEASE_CYCLES - 1)) begin
                    rel_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        entry_d         = entry_q;
        digit_count_d   = digit_count_q;
        overflow_d      = overflow_q;
        operand_d       = operand_q;
        operand_valid_d = 1'b0;
        op_code_d       = op_code_q;
        op_valid_d      = 1'b0;
        key_code_d      = key_code_q;
        key_pulse_d     = 1'b0;

        entry_ext = {4'b0000, entry_q};
        digit_ext = XW'(key_reg_q[3:0]);
        acc       = (entry_ext << 3) + (entry_ext << 1) + digit_ext;
        op_offset = key_reg_q[3:0] - 4'hA;
        is_key    = (state_q == EXEC) && (key_reg_q[7:4] == 4'h0);

        if (is_key) begin
            key_pulse_d = 1'b1;
            key_code_d  = key_reg_q[3:0];
            if (key_reg_q[3:0] <= 4'd9) begin
                if (digit_count_q < CW'(MAX_DIGITS)) begin
                    if (acc > {4'b0000, {WIDTH{1'b1}}}) begin
                        entry_d    = '1;
                        overflow_d = 1'b1;
                    end else begin
                        entry_d = acc[WIDTH-1:0];
                    end
                    digit_count_d = digit_count_q + 1'b1;
                end
            end else if (key_reg_q[3:0] <= 4'hD) begin
                op_code_d  = op_offset[1:0];
                op_valid_d = 1'b1;
                if (digit_count_q != '0) begin
                    operand_d       = entry_q;
                    operand_valid_d = 1'b1;
                end
                entry_d       = '0;
                digit_count_d = '0;
                overflow_d    = 1'b0;
            end else if (key_reg_q[3:0] == 4'hE) begin
                entry_d       = '0;
                digit_count_d = '0;
                overflow_d    = 1'b0;
            end else if (digit_count_q != '0) begin
                operand_d       = entry_q;
                operand_valid_d = 1'b1;
                entry_d         = '0;
                digit_count_d   = '0;
                overflow_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q         <= '0;
            digit_count_q   <= '0;
            overflow_q      <= 1'b0;
            operand_q       <= '0;
            operand_valid_q <= 1'b0;
            op_code_q       <= '0;
            op_valid_q      <= 1'b0;
            key_code_q      <= '0;
            key_pulse_q     <= 1'b0;
        end else begin
            entry_q         <= entry_d;
            digit_count_q   <= digit_count_d;
            overflow_q      <= overflow_d;
            operand_q       <= operand_d;
            operand_valid_q <= operand_valid_d;
            op_code_q       <= op_code_d;
            op_valid_q      <= op_valid_d;
            key_code_q      <= key_code_d;
            key_pulse_q     <= key_pulse_d;
        end
    end

    assign entry_o         = entry_q;
    assign digit_count_o   = digit_count_q;
    assign overflow_o      = overflow_q;
    assign operand_o       = operand_q;
    assign operand_valid_o = operand_valid_q;
    assign op_code_o       = op_code_q;
    assign op_valid_o      = op_valid_q;
    assign key_code_o      = key_code_q;
    assign key_pulse_o     = key_pulse_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a short release window.
module tb_keypad_entry;

    localparam int RC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tecla;
    logic       ready;
    logic [7:0] entry;
    logic [1:0] digit_count;
    logic       overflow;
    logic [7:0] operand;
    logic       operand_valid;
    logic [1:0] op_code;
    logic       op_valid;
    logic [3:0] key_code;
    logic       key_pulse;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int   kp_cnt = 0, ov_cnt = 0, opv_cnt = 0, both_cnt = 0, long_cnt = 0;
    logic kp_prev = 1'b0, ov_prev = 1'b0, opv_prev = 1'b0;

    keypad_entry #(.WIDTH(8), .MAX_DIGITS(3), .RELEASE_CYCLES(RC)) dut (
        .clk_i(clk), .rst_i(rst), .tecla_i(tecla), .ready_i(ready),
        .entry_o(entry), .digit_count_o(digit_count), .overflow_o(overflow),
        .operand_o(operand), .operand_valid_o(operand_valid),
        .op_code_o(op_code), .op_valid_o(op_valid),
        .key_code_o(key_code), .key_pulse_o(key_pulse), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_pulse === 1'b1) kp_cnt++;
        if (operand_valid === 1'b1) ov_cnt++;
        if (op_valid === 1'b1) opv_cnt++;
        if (operand_valid === 1'b1 && op_valid === 1'b1) both_cnt++;
        if ((key_pulse === 1'b1 && kp_prev) || (operand_valid === 1'b1 && ov_prev) ||
            (op_valid === 1'b1 && opv_prev)) long_cnt++;
        kp_prev  = (key_pulse === 1'b1);
        ov_prev  = (operand_valid === 1'b1);
        opv_prev = (op_valid === 1'b1);
    end

    task automatic press(input logic [7:0] code, input int hold);
        @(negedge clk);
        tecla = code;
        ready = 1'b1;
        repeat (hold) @(negedge clk);
        ready = 1'b0;
        tecla = 8'hFF;
        repeat (RC + 10) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; tecla = 8'hFF; ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (entry !== 8'd0) begin failures++; $display("FAIL rst_entry got=%0d exp=0", entry); end
        checks++; if ({digit_count, overflow, operand_valid, op_valid, key_pulse} !== 6'd0) begin
            failures++; $display("FAIL rst_flags got=%b exp=000000", {digit_count, overflow, operand_valid, op_valid, key_pulse}); end
        checks++; if ({operand, op_code, key_code} !== 14'd0) begin
            failures++; $display("FAIL rst_held got=%h exp=0", {operand, op_code, key_code}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_digits;
        int ov0, kp0;
        press(8'h01, 200);
        checks++; if (entry !== 8'd1 || digit_count !== 2'd1) begin failures++; $display("FAIL t1_d1 got=%0d/%0d exp=1/1", entry, digit_count); end
        press(8'h02, 200);
        checks++; if (entry !== 8'd12) begin failures++; $display("FAIL t1_d12 got=%0d exp=12", entry); end
        press(8'h03, 200);
        checks++; if (entry !== 8'd123 || digit_count !== 2'd3) begin failures++; $display("FAIL t1_d123 got=%0d/%0d exp=123/3", entry, digit_count); end
        ov0 = ov_cnt;
        press(8'h0F, 200);
        checks++; if (operand !== 8'd123) begin failures++; $display("FAIL t1_operand got=%0d exp=123", operand); end
        checks++; if (ov_cnt - ov0 !== 1) begin failures++; $display("FAIL t1_ov_count got=%0d exp=1", ov_cnt - ov0); end
        checks++; if (entry !== 8'd0 || digit_count !== 2'd0) begin failures++; $display("FAIL t1_cleared got=%0d/%0d exp=0/0", entry, digit_count); end
        ov0 = ov_cnt; kp0 = kp_cnt;
        press(8'h0F, 20);
        checks++; if (kp_cnt - kp0 !== 1 || ov_cnt - ov0 !== 0) begin
            failures++; $display("FAIL t1_empty_enter got=kp%0d/ov%0d exp=kp1/ov0", kp_cnt - kp0, ov_cnt - ov0); end
        checks++; if (operand !== 8'd123) begin failures++; $display("FAIL t1_operand_kept got=%0d exp=123", operand); end
    endtask

    task automatic test_debounce;
        int  kp0;
        logic [9:0] chatter;
        chatter = 10'b0100101111;
        kp0 = kp_cnt;
        @(negedge clk);
        tecla = 8'h05;
        for (int i = 0; i < 10; i++) begin
            ready = chatter[i];
            @(negedge clk);
        end
        ready = 1'b1;
        repeat (9990) @(negedge clk);
        ready = 1'b0;
        repeat (RC + 10) @(negedge clk);
        checks++; if (kp_cnt - kp0 !== 1) begin failures++; $display("FAIL t2_one_pulse got=%0d exp=1", kp_cnt - kp0); end
        checks++; if (entry !== 8'd5) begin failures++; $display("FAIL t2_entry got=%0d exp=5", entry); end
    endtask

    task automatic test_saturate;
        int kp0;
        press(8'h0E, 20);
        checks++; if (entry !== 8'd0) begin failures++; $display("FAIL t3_pre_clear got=%0d exp=0", entry); end
        press(8'h02, 20);
        press(8'h05, 20);
        checks++; if (entry !== 8'd25 || overflow !== 1'b0) begin failures++; $display("FAIL t3_d25 got=%0d/%b exp=25/0", entry, overflow); end
        press(8'h06, 20);
        checks++; if (entry !== 8'd255 || overflow !== 1'b1) begin failures++; $display("FAIL t3_sat got=%0d/%b exp=255/1", entry, overflow); end
        kp0 = kp_cnt;
        press(8'h07, 20);
        checks++; if (kp_cnt - kp0 !== 1 || entry !== 8'd255 || digit_count !== 2'd3) begin
            failures++; $display("FAIL t3_max_digits got=kp%0d/%0d/%0d exp=kp1/255/3", kp_cnt - kp0, entry, digit_count); end
        checks++; if (key_code !== 4'h7) begin failures++; $display("FAIL t3_key_code got=%h exp=7", key_code); end
        press(8'h0E, 20);
        checks++; if (entry !== 8'd0 || overflow !== 1'b0 || digit_count !== 2'd0) begin
            failures++; $display("FAIL t3_clear got=%0d/%b/%0d exp=0/0/0", entry, overflow, digit_count); end
    endtask

    task automatic test_operator;
        int ov0, opv0, both0;
        press(8'h04, 20);
        ov0 = ov_cnt; opv0 = opv_cnt; both0 = both_cnt;
        press(8'h0B, 20);
        checks++; if (operand !== 8'd4 || op_code !== 2'd1) begin failures++; $display("FAIL t4_op_b got=%0d/%0d exp=4/1", operand, op_code); end
        checks++; if (both_cnt - both0 !== 1 || ov_cnt - ov0 !== 1 || opv_cnt - opv0 !== 1) begin
            failures++; $display("FAIL t4_same_cycle got=both%0d/ov%0d/op%0d exp=1/1/1", both_cnt - both0, ov_cnt - ov0, opv_cnt - opv0); end
        checks++; if (entry !== 8'd0) begin failures++; $display("FAIL t4_entry_clr got=%0d exp=0", entry); end
        ov0 = ov_cnt; opv0 = opv_cnt;
        press(8'h0C, 20);
        checks++; if (op_code !== 2'd2 || operand !== 8'd4) begin failures++; $display("FAIL t4_op_c got=%0d/%0d exp=2/4", op_code, operand); end
        checks++; if (opv_cnt - opv0 !== 1 || ov_cnt - ov0 !== 0) begin
            failures++; $display("FAIL t4_op_only got=op%0d/ov%0d exp=1/0", opv_cnt - opv0, ov_cnt - ov0); end
    endtask

    task automatic test_invalid_code;
        int kp0;
        kp0 = kp_cnt;
        press(8'h20, 20);
        checks++; if (kp_cnt - kp0 !== 0 || key_code !== 4'hC) begin
            failures++; $display("FAIL inv_no_action got=kp%0d/%h exp=kp0/c", kp_cnt - kp0, key_code); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL inv_rearmed got=%b exp=0", busy); end
    endtask

    task automatic test_glitch_and_reset;
        int kp0;
        kp0 = kp_cnt;
        @(negedge clk); tecla = 8'h03; ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t5_glitch_busy got=%b exp=1", busy); end
        repeat (RC + 10) @(negedge clk);
        checks++; if (busy !== 1'b0 || kp_cnt - kp0 !== 0) begin
            failures++; $display("FAIL t5_glitch got=busy%b/kp%0d exp=0/0", busy, kp_cnt - kp0); end
        press(8'h09, 20);
        @(posedge clk);
        @(negedge clk); tecla = 8'h04; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || key_pulse !== 1'b0 || entry !== 8'd9) begin
            failures++; $display("FAIL t5_exec_pre got=busy%b/kp%b/%0d exp=1/0/9", busy, key_pulse, entry); end
        rst = 1'b1;
        #1;
        checks++; if ({entry, operand, op_code, key_code, digit_count, busy} !== 25'd0) begin
            failures++; $display("FAIL t5_async_rst got=%h exp=0", {entry, operand, op_code, key_code, digit_count, busy}); end
        @(negedge clk); ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latency;
        int kp0;
        kp0 = kp_cnt;
        @(posedge clk);
        @(negedge clk); tecla = 8'h01; ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (key_pulse !== 1'b0) begin failures++; $display("FAIL t6_early got=%b exp=0", key_pulse); end
        @(posedge clk);
        #1;
        checks++; if (key_pulse !== 1'b1 || entry !== 8'd1) begin failures++; $display("FAIL t6_latency got=%b/%0d exp=1/1", key_pulse, entry); end
        repeat (10) @(negedge clk);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        tecla = 8'h02; ready = 1'b1;
        repeat (20) @(negedge clk);
        ready = 1'b0;
        repeat (RC + 10) @(negedge clk);
        checks++; if (kp_cnt - kp0 !== 1 || entry !== 8'd1 || digit_count !== 2'd1) begin
            failures++; $display("FAIL t6_second_ignored got=kp%0d/%0d/%0d exp=1/1/1", kp_cnt - kp0, entry, digit_count); end
        checks++; if (long_cnt !== 0) begin failures++; $display("FAIL pulse_width got=%0d exp=0", long_cnt); end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_debounce();
        test_saturate();
        test_operator();
        test_invalid_code();
        test_glitch_and_reset();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
